// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module : eq_pkg
// Shared widths, FSM encodings and the 16-bit saturation helper.
// Rev    : 1.0
// ============================================================================
package eq_pkg;
    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 13;
    localparam int ACC_W    = 20;
    localparam int PROD_W   = 29;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BAND  = 2'd1;
    localparam logic [1:0] S_VOL_L = 2'd2;
    localparam logic [1:0] S_VOL_R = 2'd3;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [PROD_W-1:0] x);
        if (x > 32767)
            return 16'sh7fff;
        else if (x < -32768)
            return 16'sh8000;
        else
            return x[SAMPLE_W-1:0];
    endfunction
endpackage
`default_nettype wire

// File: rtl/eq_mul_sat.sv
`default_nettype none
// ============================================================================
// Module : eq_mul_sat
// Shared signed 16x13 multiply, Q1.11 floor shift, with raw and clamped results.
// Rev    : 1.0
// ============================================================================
module eq_mul_sat
    import eq_pkg::*;
#(
    parameter int GAIN_FRAC = 11
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [GAIN_W-1:0]   gain,
    output logic signed [PROD_W-1:0]   term,
    output logic signed [SAMPLE_W-1:0] sat
);
    logic signed [PROD_W-1:0] w_s_ext;
    logic signed [PROD_W-1:0] w_g_ext;
    logic signed [PROD_W-1:0] w_prod;

    assign w_s_ext = {{(PROD_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    assign w_g_ext = {{(PROD_W-GAIN_W){gain[GAIN_W-1]}}, gain};
    assign w_prod  = w_s_ext * w_g_ext;
    assign term    = w_prod >>> GAIN_FRAC;
    assign sat     = sat16(term);
endmodule
`default_nettype wire

// File: rtl/eq_band_sched.sv
`default_nettype none
// ============================================================================
// Module : eq_band_sched
// Time-multiplexed 5-band stereo EQ controller with volume and amp-on delay.
// Rev    : 1.0
// ============================================================================
module eq_band_sched
    import eq_pkg::*;
#(
    parameter int AMP_DLY   = 1024,
    parameter int GAIN_FRAC = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic signed [SAMPLE_W-1:0] band_lft,
    input  logic signed [SAMPLE_W-1:0] band_rht,
    input  logic signed [GAIN_W-1:0]   LP_gain,
    input  logic signed [GAIN_W-1:0]   B1_gain,
    input  logic signed [GAIN_W-1:0]   B2_gain,
    input  logic signed [GAIN_W-1:0]   B3_gain,
    input  logic signed [GAIN_W-1:0]   HP_gain,
    input  logic signed [GAIN_W-1:0]   volume,
    output logic [2:0]                 band_sel,
    output logic signed [SAMPLE_W-1:0] lft_out,
    output logic signed [SAMPLE_W-1:0] rht_out,
    output logic                       out_vld,
    output logic                       ovr,
    output logic                       amp_on
);
    localparam int                CNT_W      = $clog2(AMP_DLY + 1);
    localparam logic [CNT_W-1:0]  C_AMP_DLY  = CNT_W'(AMP_DLY);
    localparam logic [CNT_W-1:0]  C_AMP_LAST = CNT_W'(AMP_DLY - 1);

    logic [1:0]                 r_state;
    logic [3:0]                 r_step;
    logic                       r_valid_q;
    logic signed [ACC_W-1:0]    r_acc_l;
    logic signed [ACC_W-1:0]    r_acc_r;
    logic signed [SAMPLE_W-1:0] r_hold_l;
    logic [CNT_W-1:0]           r_frames;

    logic                       w_start;
    logic signed [GAIN_W-1:0]   w_band_gain;
    logic signed [SAMPLE_W-1:0] w_mul_s;
    logic signed [GAIN_W-1:0]   w_mul_g;
    logic signed [PROD_W-1:0]   w_term;
    logic signed [SAMPLE_W-1:0] w_sat;
    logic signed [ACC_W-1:0]    w_term_acc;

    assign w_start    = valid & ~r_valid_q;
    assign band_sel   = r_step[3:1];
    assign w_term_acc = $signed(w_term[ACC_W-1:0]);

    always_comb begin
        w_band_gain = '0;
        case (band_sel)
            3'd0:    w_band_gain = LP_gain;
            3'd1:    w_band_gain = B1_gain;
            3'd2:    w_band_gain = B2_gain;
            3'd3:    w_band_gain = B3_gain;
            3'd4:    w_band_gain = HP_gain;
            default: w_band_gain = '0;
        endcase
    end

    // One multiplier serves both the band steps and the two volume steps.
    always_comb begin
        w_mul_s = r_step[0] ? band_rht : band_lft;
        w_mul_g = w_band_gain;
        if (r_state == S_VOL_L) begin
            w_mul_s = sat16(PROD_W'(r_acc_l));
            w_mul_g = volume;
        end else if (r_state == S_VOL_R) begin
            w_mul_s = sat16(PROD_W'(r_acc_r));
            w_mul_g = volume;
        end
    end

    eq_mul_sat #(
        .GAIN_FRAC (GAIN_FRAC)
    ) u_mul (
        .sample (w_mul_s),
        .gain   (w_mul_g),
        .term   (w_term),
        .sat    (w_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_valid_q <= 1'b0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_hold_l  <= '0;
            r_frames  <= '0;
            lft_out   <= '0;
            rht_out   <= '0;
            out_vld   <= 1'b0;
            ovr       <= 1'b0;
            amp_on    <= 1'b0;
        end else begin
            r_valid_q <= valid;
            out_vld   <= 1'b0;

            if (out_vld && r_frames != C_AMP_DLY)
                r_frames <= r_frames + 1'b1;
            if (out_vld && r_frames == C_AMP_LAST)
                amp_on <= 1'b1;

            if (w_start && r_state != S_IDLE)
                ovr <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_BAND;
                        r_step  <= '0;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                    end
                end
                S_BAND: begin
                    if (r_step[0])
                        r_acc_r <= r_acc_r + w_term_acc;
                    else
                        r_acc_l <= r_acc_l + w_term_acc;
                    if (r_step == 4'd9) begin
                        r_step  <= '0;
                        r_state <= S_VOL_L;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_VOL_L: begin
                    r_hold_l <= w_sat;
                    r_state  <= S_VOL_R;
                end
                S_VOL_R: begin
                    lft_out <= r_hold_l;
                    rht_out <= w_sat;
                    out_vld <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_eq_band_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_eq_band_sched
// Scoreboard bench for eq_band_sched with a modelled external band mux.
// Rev    : 1.0
// ============================================================================
module tb_eq_band_sched;
    localparam int AMP = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid;
    logic signed [15:0] band_lft, band_rht;
    logic signed [12:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, volume;
    logic [2:0]         band_sel;
    logic signed [15:0] lft_out, rht_out;
    logic               out_vld, ovr, amp_on;

    logic signed [15:0] samp_l [5];
    logic signed [15:0] samp_r [5];

    always #5 clk = ~clk;

    assign band_lft = (band_sel < 3'd5) ? samp_l[band_sel] : 16'sd0;
    assign band_rht = (band_sel < 3'd5) ? samp_r[band_sel] : 16'sd0;

    eq_band_sched #(
        .AMP_DLY   (AMP),
        .GAIN_FRAC (11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .band_lft (band_lft),
        .band_rht (band_rht),
        .LP_gain  (LP_gain),
        .B1_gain  (B1_gain),
        .B2_gain  (B2_gain),
        .B3_gain  (B3_gain),
        .HP_gain  (HP_gain),
        .volume   (volume),
        .band_sel (band_sel),
        .lft_out  (lft_out),
        .rht_out  (rht_out),
        .out_vld  (out_vld),
        .ovr      (ovr),
        .amp_on   (amp_on)
    );

    typedef struct {
        int l;
        int r;
        int at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   seen  = 0;
    bit   chk_amp_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every out_vld and tracks the amp delay.
    always @(negedge clk) begin
        exp_t e;
        if (chk_amp_next) begin
            check("amp_after_vld", int'(amp_on), int'(seen >= AMP));
            chk_amp_next = 1'b0;
        end
        if (rst_n && out_vld) begin
            check("amp_at_vld", int'(amp_on), int'(seen >= AMP));
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld: got out_vld=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("lft_out", int'(lft_out), e.l);
                check("rht_out", int'(rht_out), e.r);
                check("latency", cyc, e.at);
            end
            seen++;
            chk_amp_next = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_uniform(input int sl, input int sr, input int g, input int vol);
        for (int i = 0; i < 5; i++) begin
            samp_l[i] = 16'(sl);
            samp_r[i] = 16'(sr);
        end
        LP_gain = 13'(g); B1_gain = 13'(g); B2_gain = 13'(g);
        B3_gain = 13'(g); HP_gain = 13'(g);
        volume  = 13'(vol);
    endtask

    // Called just after a posedge: start is seen on the next edge, output 12 edges later.
    task automatic frame(input int el, input int er, input bit chk_sel);
        exp_t e;
        e.l = el; e.r = er; e.at = cyc + 13;
        q.push_back(e);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        if (chk_sel) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("band_sel", int'(band_sel), k >> 1);
            end
        end
        tick(chk_sel ? 6 : 15);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        set_uniform(0, 0, 0, 0);
        tick(3);
        check("rst_lft", int'(lft_out), 0);
        check("rst_rht", int'(rht_out), 0);
        check("rst_vld", int'(out_vld), 0);
        check("rst_ovr", int'(ovr), 0);
        check("rst_amp", int'(amp_on), 0);
        check("rst_sel", int'(band_sel), 0);
        rst_n = 1'b1;
        tick(2);

        set_uniform(1000, -1000, 2048, 2048);
        frame(5000, -5000, 1'b0);

        set_uniform(20000, -20000, 2048, 1024);
        frame(16383, -16384, 1'b0);

        set_uniform(30000, 30000, 0, 2048);
        LP_gain   = 13'sd4095;
        samp_l[0] = 16'sd8192;
        samp_r[0] = 16'sd8192;
        frame(16380, 16380, 1'b1);
        check("ovr_clear", int'(ovr), 0);
        check("amp_pre", int'(amp_on), 0);

        // Reset while the band walk is at step 6.
        set_uniform(1000, -1000, 2048, 2048);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        tick(6);
        check("midrst_step6_sel", int'(band_sel), 3);
        rst_n = 1'b0;
        tick(1);
        seen  = 0;
        rst_n = 1'b1;
        check("midrst_lft", int'(lft_out), 0);
        check("midrst_rht", int'(rht_out), 0);
        check("midrst_amp", int'(amp_on), 0);
        check("midrst_sel", int'(band_sel), 0);
        tick(15);

        // Overrun: second rise five clocks after the first.
        begin
            exp_t e;
            e.l = 5000; e.r = -5000; e.at = cyc + 13;
            q.push_back(e);
        end
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        tick(4);
        valid = 1'b1;
        tick(2);
        valid = 1'b0;
        tick(12);
        check("ovr_set", int'(ovr), 1);

        for (int f = 0; f < 4; f++)
            frame(5000, -5000, 1'b0);
        check("ovr_sticky", int'(ovr), 1);
        check("amp_final", int'(amp_on), 1);

        tick(3);
        check("pending_exp", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
